// File: rtl/matrix_feed_ctrl_if.sv
// Bus bundle for matrix_feed_ctrl: host byte stream, 4x4 memory port and skewed feed outputs.
// master = host/memory side, slave = controller side.
interface matrix_feed_ctrl_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [31:0] mem_row;
  logic [31:0] feed_data;
  logic [3:0]  feed_lane_valid;
  logic        feed_valid;
  logic        busy;
  logic        done;

  modport master (
    output start, in_valid, in_data, mem_row,
    input  in_ready, mem_we, mem_addr, mem_data,
    input  feed_data, feed_lane_valid, feed_valid, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, mem_row,
    output in_ready, mem_we, mem_addr, mem_data,
    output feed_data, feed_lane_valid, feed_valid, busy, done
  );
endinterface

// File: rtl/matrix_feed_ctrl.sv
// Loads 16 host bytes into a 4x4 memory, then streams its rows to an array with optional per-lane skew.
// Macro FEED_SKEW_EN: when defined, lane i of each row is delayed i extra cycles.
module matrix_feed_ctrl #(
  parameter int FEED_GAP = 0
) (
  input logic               clk,
  input logic               reset,
  matrix_feed_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, DONE} state_e;

  localparam logic [3:0] GAP = 4'(FEED_GAP);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  row_q;
  logic [3:0]  gap_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic [3:0]  mem_addr_q;
  logic [7:0]  mem_data_q;
  logic [31:0] feed_data_q;
  logic [3:0]  lane_valid_q;
  logic        busy_q;
  logic        done_q;

  logic accept_d;
  logic row_cap_d;
  logic pipe_empty_d;

  assign accept_d  = in_ready_q & bus.in_valid;
  assign row_cap_d = (state_q == FEED) && (gap_q == '0);

`ifdef FEED_SKEW_EN
  // Triangular delay line: each stage keeps only the lanes still waiting.
  logic [23:0] s1_q;
  logic [15:0] s2_q;
  logic [7:0]  s3_q;
  logic [2:0]  sv_q;

  assign pipe_empty_d = (sv_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      sv_q         <= '0;
      feed_data_q  <= '0;
      lane_valid_q <= '0;
    end else begin
      feed_data_q[7:0]   <= row_cap_d ? bus.mem_row[7:0] : '0;
      lane_valid_q[0]    <= row_cap_d;
      s1_q               <= bus.mem_row[31:8];
      sv_q[0]            <= row_cap_d;
      feed_data_q[15:8]  <= sv_q[0] ? s1_q[7:0] : '0;
      lane_valid_q[1]    <= sv_q[0];
      s2_q               <= s1_q[23:8];
      sv_q[1]            <= sv_q[0];
      feed_data_q[23:16] <= sv_q[1] ? s2_q[7:0] : '0;
      lane_valid_q[2]    <= sv_q[1];
      s3_q               <= s2_q[15:8];
      sv_q[2]            <= sv_q[1];
      feed_data_q[31:24] <= sv_q[2] ? s3_q : '0;
      lane_valid_q[3]    <= sv_q[2];
    end
  end
`else
  assign pipe_empty_d = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      feed_data_q  <= '0;
      lane_valid_q <= '0;
    end else begin
      feed_data_q  <= row_cap_d ? bus.mem_row : '0;
      lane_valid_q <= {4{row_cap_d}};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      gap_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_d) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= cnt_q;
            mem_data_q <= bus.in_data;
            cnt_q      <= cnt_q + 4'd1;
            if (cnt_q == 4'hF) in_ready_q <= 1'b0;
          end
          // Leave only once the final write is on the bus, so F0 addresses row 0 of a full memory.
          if (mem_we_q && (mem_addr_q == 4'hF)) begin
            state_q    <= FEED;
            mem_addr_q <= '0;
            row_q      <= '0;
            gap_q      <= '0;
          end
        end
        FEED: begin
          if (gap_q == GAP) begin
            gap_q      <= '0;
            row_q      <= row_q + 2'd1;
            mem_addr_q <= {row_q + 2'd1, 2'b00};
          end else begin
            gap_q <= gap_q + 4'd1;
          end
          if (row_cap_d && (row_q == 2'd3)) begin
            state_q    <= FLUSH;
            mem_addr_q <= '0;
          end
        end
        FLUSH: begin
          if (pipe_empty_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_data        = mem_data_q;
  assign bus.feed_data       = feed_data_q;
  assign bus.feed_lane_valid = lane_valid_q;
  assign bus.feed_valid      = |lane_valid_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_matrix_feed_ctrl.sv
// Scoreboard bench for matrix_feed_ctrl: randomized loads, expected writes/feed/done queued, monitor compares.
module tb_matrix_feed_ctrl;
  parameter int FEED_GAP = 0;

  typedef logic [7:0] blk_t [16];
  typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int off; logic [3:0] lv; logic [31:0] data; } fe_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   f0 = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   done_target = 0;

  wr_t wq[$];
  fe_t fq[$];
  int  dq[$];

  logic [7:0] mem [16];

  matrix_feed_ctrl_if bus ();

  matrix_feed_ctrl #(.FEED_GAP(FEED_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
  assign bus.mem_row = {mem[{bus.mem_addr[3:2], 2'd3}], mem[{bus.mem_addr[3:2], 2'd2}],
                        mem[{bus.mem_addr[3:2], 2'd1}], mem[{bus.mem_addr[3:2], 2'd0}]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {11'd0, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_data, bus.feed_data,
               bus.feed_lane_valid, bus.feed_valid, bus.busy, bus.done}, 64'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, a feed beat or done.
  initial begin
    wr_t w;
    fe_t e;
    int  d;
    forever begin
      @(negedge clk);
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", {bus.mem_addr, bus.mem_data}, 64'd0);
          if ({bus.mem_addr, bus.mem_data} == 12'd0) chk("wr_unexpected_zero", 64'd1, 64'd0);
        end else begin
          w = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(w.cyc));
          chk("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
          chk("wr_data", 64'(bus.mem_data), 64'(w.data));
          if (w.addr == 4'hF) f0 = cyc + 1;
        end
      end
      if (bus.feed_valid) begin
        if (fq.size() == 0) begin
          chk("feed_unexpected_lv", 64'(bus.feed_lane_valid), 64'd0);
        end else begin
          e = fq.pop_front();
          chk("feed_offset", 64'(cyc - f0), 64'(e.off));
          chk("feed_lane_valid", 64'(bus.feed_lane_valid), 64'(e.lv));
          chk("feed_data", 64'(bus.feed_data), 64'(e.data));
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 64'(bus.done), 64'd0);
        end else begin
          d = dq.pop_front();
          chk("done_offset", 64'(cyc - f0), 64'(d));
          chk("busy_at_done", 64'(bus.busy), 64'd1);
        end
        done_seen++;
      end
    end
  end

  // Reference schedule: row r lane i appears (1+GAP)*r + 1 (+i when skewed) cycles after F0.
  task automatic push_feed(input blk_t b);
    int  last;
    fe_t fe;
    last = 0;
    for (int t = 1; t <= 3 * (1 + FEED_GAP) + 5; t++) begin
      fe.off  = t;
      fe.lv   = '0;
      fe.data = '0;
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < 4; i++) begin
          int due;
`ifdef FEED_SKEW_EN
          due = r * (1 + FEED_GAP) + 1 + i;
`else
          due = r * (1 + FEED_GAP) + 1;
`endif
          if (due == t) begin
            fe.lv[i]          = 1'b1;
            fe.data[8*i +: 8] = b[4*r + i];
          end
        end
      end
      if (fe.lv != '0) begin
        fq.push_back(fe);
        last = t;
      end
    end
    dq.push_back(last + 1);
    done_target++;
  endtask

  task automatic start_seq();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // pat 0: back-to-back, 1: every other cycle, 2: random gaps with garbage data when idle.
  task automatic load_bytes(input blk_t b, input int pat, input int nbytes);
    int   k;
    int   n;
    logic v;
    wr_t  w;
    k = 0;
    n = 0;
    while (k < nbytes && n < 400) begin
      v = (pat == 0) ? 1'b1 : (pat == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_data  = v ? b[k] : 8'($urandom);
      @(negedge clk);
      if (v && bus.in_ready) begin
        w.cyc  = cyc + 1;
        w.addr = 4'(k);
        w.data = b[k];
        wq.push_back(w);
        k++;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (k < nbytes) chk("load_timeout_bytes", 64'(k), 64'(nbytes));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < done_target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_count", 64'(done_seen), 64'(done_target));
    @(negedge clk);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("done_single_pulse", 64'(bus.done), 64'd0);
  endtask

  task automatic run_full(input blk_t b, input int pat, input bit restart_in_feed);
    push_feed(b);
    start_seq();
    load_bytes(b, pat, 16);
    @(negedge clk);
    chk("in_ready_after_16", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    if (restart_in_feed) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    wait_done();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    blk_t b;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Traffic while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    for (int k = 0; k < 16; k++) b[k] = 8'(k + 1);
    run_full(b, 0, 1'b0);
    run_full(b, 1, 1'b0);

    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    run_full(b, 2, 1'b1);

    // Abort after 7 bytes; reset must beat start and a pending transfer.
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    start_seq();
    load_bytes(b, 0, 7);
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) b[k] = 8'(8'hA0 + k);
    run_full(b, 2, 1'b0);

    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
      run_full(b, 2, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("wr_queue_left", 64'(wq.size()), 64'd0);
    chk("feed_queue_left", 64'(fq.size()), 64'd0);
    chk("done_queue_left", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_feed_ctrl.md
MATRIX_FEED_CTRL -- requirements
Module: matrix_feed_ctrl

Interface
REQ-001 SHALL have parameter: FEED_GAP, 0, idle cycles inserted between consecutive row reads during FEED (legal 0..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request to begin a load-then-feed sequence; sampled only in IDLE.
REQ-005 SHALL have ports: in_valid  in  1 / in_data  in  8 / in_ready  out  1  host byte stream; a byte transfers when in_valid and in_ready are both high at the rising edge.
REQ-006 SHALL have ports: mem_we  out  1 / mem_addr  out  4 / mem_data  out  8  write/row-select port to the 4x4 byte memory.
REQ-007 SHALL have port: mem_row  in  32  combinational row of memory selected by mem_addr[3:2]; byte i = bits [8i+7:8i] = address {row,i}.
REQ-008 SHALL have ports: feed_data  out  32 / feed_lane_valid  out  4 / feed_valid  out  1  skewed row stream to the array; feed_valid = OR of feed_lane_valid.
REQ-009 SHALL have ports: busy  out  1 / done  out  1  busy high from IDLE exit through the done cycle; done is a one-cycle pulse.

Function
REQ-010 SHALL implement states IDLE, LOAD, FEED, FLUSH, DONE; IDLE->LOAD on start, LOAD->FEED after 16th write issued, FEED->FLUSH after row 3 addressed, FLUSH->DONE when skew pipeline empty, DONE->IDLE unconditionally.
REQ-011 SHALL assert in_ready only in LOAD while fewer than 16 bytes accepted; in_ready low the cycle after the 16th acceptance.
REQ-012 SHALL write accepted byte k (k=0..15) to address k: registered, mem_we=1, mem_addr=k, mem_data=byte on the cycle after acceptance.
REQ-013 SHALL hold mem_we=0 in every state except the write cycles of REQ-012.
REQ-014 SHALL, in FEED, drive mem_addr={r,2'b00} for row r=0..3, one row per 1+FEED_GAP cycles, and capture mem_row at the end of that cycle.
REQ-015 SHALL present lane i of row r on feed_data[8i+7:8i] with feed_lane_valid[i]=1 exactly 1+i cycles after row r address cycle (FEED_GAP=0: cycle F0+1+r+i, F0 = first FEED cycle).
REQ-016 SHALL drive 0 on any feed_data lane whose feed_lane_valid bit is 0.
REQ-017 SHALL pulse done one cycle after the last valid lane (FEED_GAP=0, skew on: done at F0+8).
REQ-018 SHALL ignore start when not IDLE and ignore in_valid/in_data when in_ready is 0.
REQ-019 SHALL not time out in LOAD; in_valid gaps of any length only stall.

Reset
REQ-020 SHALL, when reset is high at an edge, enter IDLE and clear counters and skew pipeline; reset wins over start and over a transfer in the same cycle.
REQ-021 SHALL reset outputs to: in_ready=0, mem_we=0, mem_addr=0, mem_data=0, feed_data=0, feed_lane_valid=0, feed_valid=0, busy=0, done=0.
REQ-022 SHALL leave memory contents untouched on reset mid-operation; next start reloads all 16 bytes.

Configuration
REQ-023 SHALL, with FEED_SKEW_EN defined, apply per-lane skew of REQ-015.
REQ-024 SHALL, without FEED_SKEW_EN, present all four lanes of row r together at F0+1+r (FEED_GAP=0), feed_lane_valid=4'hF for 4 cycles, done at F0+5.

Verification
REQ-025 SHALL cover: start, bytes 0x01..0x10 back-to-back, skew on -> writes addr 0..15, lane0 0x01,0x05,0x09,0x0D at F0+1..F0+4, lane3 0x04..0x10 at F0+4..F0+7, done at F0+8.
REQ-026 SHALL cover: in_valid toggled every other cycle during LOAD -> exactly 16 writes, no duplicate or skipped address, feed identical to REQ-025.
REQ-027 SHALL cover: start asserted again during FEED and in_valid high in IDLE -> no effect, in_ready stays 0, single done pulse.
REQ-028 SHALL cover: reset after 7 bytes loaded -> all outputs at reset values next cycle; restart with 0xA0..0xAF -> feed shows only new bytes.
REQ-029 SHALL cover: FEED_GAP=2 -> rows addressed at F0, F0+3, F0+6, F0+9; lane i of row r valid at F0+3r+1+i.
REQ-030 SHALL cover: FEED_SKEW_EN undefined, same data as REQ-025 -> feed_data 0x04030201 at F0+1 ... 0x100F0E0D at F0+4, done at F0+5.
